// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of a single ALU.
// Selects one ready micro-op per cycle and forms its operands.
// The micro-op is registered into a one-entry issue stage with a
// valid/ready handshake toward the ALU.
// Optional build macro: ALU_ARB_PERF_EN adds per-requester grant counters and a stall counter.
module alu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned CNT_W   = 32,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*7-1:0]     req_opcode,
  input  logic [NUM_REQ*3-1:0]     req_funct3,
  input  logic [NUM_REQ*7-1:0]     req_funct7,
  input  logic [NUM_REQ*XLEN-1:0]  req_rs1,
  input  logic [NUM_REQ*XLEN-1:0]  req_rs2,
  input  logic [NUM_REQ*XLEN-1:0]  req_imm,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [6:0]               iss_opcode,
  output logic [2:0]               iss_funct3,
  output logic [6:0]               iss_funct7,
  output logic [XLEN-1:0]          iss_op_a,
  output logic [XLEN-1:0]          iss_op_b,
  output logic [TAG_W-1:0]         iss_tag,
  output logic [IDX_W-1:0]         iss_src
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] perf_grant_cnt,
  output logic [CNT_W-1:0]         perf_stall_cnt
`endif
);

  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic [IDX_W-1:0]   rr_ptr;
  logic               load_en;
  logic               accept;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_next;
  logic [6:0]         sel_opcode;
  logic [XLEN-1:0]    sel_op_b;

  // Stage can take a new uop when empty or draining this cycle; rst and flush block acceptance.
  assign load_en = !rst && !flush && (!iss_valid || iss_ready);

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : p_grant
    int unsigned j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  assign req_ready = grant & {NUM_REQ{load_en}};
  assign accept    = grant_any && load_en;
  assign rr_next   = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Operand B is the immediate only for OP-IMM encodings.
  always_comb begin
    sel_opcode = req_opcode[grant_idx*7 +: 7];
    sel_op_b   = (sel_opcode == OP_IMM) ? req_imm[grant_idx*XLEN +: XLEN]
                                        : req_rs2[grant_idx*XLEN +: XLEN];
  end

  // Issue stage and round-robin pointer; flush empties the stage but keeps the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid  <= 1'b0;
      iss_opcode <= '0;
      iss_funct3 <= '0;
      iss_funct7 <= '0;
      iss_op_a   <= '0;
      iss_op_b   <= '0;
      iss_tag    <= '0;
      iss_src    <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (accept) begin
      iss_valid  <= 1'b1;
      iss_opcode <= sel_opcode;
      iss_funct3 <= req_funct3[grant_idx*3 +: 3];
      iss_funct7 <= req_funct7[grant_idx*7 +: 7];
      iss_op_a   <= req_rs1[grant_idx*XLEN +: XLEN];
      iss_op_b   <= sel_op_b;
      iss_tag    <= req_tag[grant_idx*TAG_W +: TAG_W];
      iss_src    <= grant_idx;
      rr_ptr     <= rr_next;
    end else if (iss_valid && iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Free-running wrap-around counters, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) begin
        perf_grant_cnt[grant_idx*CNT_W +: CNT_W] <=
          perf_grant_cnt[grant_idx*CNT_W +: CNT_W] + 1'b1;
      end
      if (iss_valid && !iss_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the arbiter and issue stage.
module tb_alu_issue_arbiter;
  localparam int N = 4, XLEN = 32, TAG_W = 6, CNT_W = 32;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  logic clk = 1'b0;
  logic rst, flush, iss_ready;
  logic [N-1:0]       req_valid, req_ready;
  logic [N*7-1:0]     req_opcode, req_funct7;
  logic [N*3-1:0]     req_funct3;
  logic [N*XLEN-1:0]  req_rs1, req_rs2, req_imm;
  logic [N*TAG_W-1:0] req_tag;
  logic               iss_valid;
  logic [6:0]         iss_opcode, iss_funct7;
  logic [2:0]         iss_funct3;
  logic [XLEN-1:0]    iss_op_a, iss_op_b;
  logic [TAG_W-1:0]   iss_tag;
  logic [1:0]         iss_src;
`ifdef ALU_ARB_PERF_EN
  logic [N*CNT_W-1:0] perf_grant_cnt;
  logic [CNT_W-1:0]   perf_stall_cnt;
`endif

  int tests_run = 0, tests_failed = 0;

  // Model state
  int          m_rr;
  bit          m_valid;
  logic [6:0]  m_opcode, m_funct7;
  logic [2:0]  m_funct3;
  logic [XLEN-1:0] m_a, m_b;
  logic [TAG_W-1:0] m_tag;
  int          m_src;
  int unsigned m_gcnt[N];
  int unsigned m_stall;

  alu_issue_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_tag(req_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_opcode(iss_opcode), .iss_funct3(iss_funct3), .iss_funct7(iss_funct7),
    .iss_op_a(iss_op_a), .iss_op_b(iss_op_b), .iss_tag(iss_tag), .iss_src(iss_src)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // First valid requester at or after the pointer, wrapping; -1 if none.
  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic [N-1:0] one;
    g = exp_grant();
    one = 1;
    if (!rst && !flush && (!m_valid || iss_ready) && g >= 0) return one << g;
    return '0;
  endfunction

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_update();
    int g;
    g = exp_grant();
    if (rst) begin
      m_rr = 0; m_valid = 0; m_opcode = 0; m_funct3 = 0; m_funct7 = 0;
      m_a = 0; m_b = 0; m_tag = 0; m_src = 0; m_stall = 0;
      for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    end else begin
      if (m_valid && !iss_ready) m_stall++;
      if (flush) begin
        m_valid = 0;
      end else if (g >= 0 && (!m_valid || iss_ready)) begin
        m_gcnt[g]++;
        m_opcode = req_opcode[g*7 +: 7];
        m_funct3 = req_funct3[g*3 +: 3];
        m_funct7 = req_funct7[g*7 +: 7];
        m_a      = req_rs1[g*XLEN +: XLEN];
        m_b      = (m_opcode == OP_IMM) ? req_imm[g*XLEN +: XLEN] : req_rs2[g*XLEN +: XLEN];
        m_tag    = req_tag[g*TAG_W +: TAG_W];
        m_src    = g;
        m_rr     = (g + 1) % N;
        m_valid  = 1;
      end else if (m_valid && iss_ready) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [6:0] opc, input logic [XLEN-1:0] rs1,
                         input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm,
                         input logic [TAG_W-1:0] tag);
    req_opcode[i*7 +: 7]       = opc;
    req_funct3[i*3 +: 3]       = 3'(i);
    req_funct7[i*7 +: 7]       = 7'h20;
    req_rs1[i*XLEN +: XLEN]    = rs1;
    req_rs2[i*XLEN +: XLEN]    = rs2;
    req_imm[i*XLEN +: XLEN]    = imm;
    req_tag[i*TAG_W +: TAG_W]  = tag;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < N; i++) begin
      set_req(i, ($urandom_range(0, 1) == 1) ? OP_IMM : (($urandom_range(0, 1) == 1) ? OP : 7'($urandom)),
              $urandom, $urandom, $urandom, TAG_W'($urandom));
      req_funct3[i*3 +: 3] = 3'($urandom);
      req_funct7[i*7 +: 7] = 7'($urandom);
    end
  endtask

  task automatic reset_dut();
    rst = 1; flush = 0; req_valid = '0; iss_ready = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    randomize_fields();
    reset_dut();
    rst = 1; req_valid = '1; #1;
    tests_run++;
    if (req_ready !== '0) begin
      tests_failed++; $display("FAIL reset_req_ready got %b exp 0000", req_ready);
    end
    tests_run++;
    if ({iss_valid, iss_opcode, iss_funct3, iss_funct7, iss_op_a, iss_op_b, iss_tag, iss_src} !== '0) begin
      tests_failed++;
      $display("FAIL reset_iss got v=%b a=%h b=%h tag=%h src=%0d exp all 0",
               iss_valid, iss_op_a, iss_op_b, iss_tag, iss_src);
    end
`ifdef ALU_ARB_PERF_EN
    tests_run++;
    if (perf_grant_cnt !== '0 || perf_stall_cnt !== '0) begin
      tests_failed++; $display("FAIL reset_perf got g=%h s=%h exp 0", perf_grant_cnt, perf_stall_cnt);
    end
`endif
    rst = 0; req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] one;
    one = 1;
    reset_dut();
    randomize_fields();
    req_valid = 4'b1111; iss_ready = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++;
      if (req_ready !== (one << (k % 4)) || iss_valid !== (k > 0)) begin
        tests_failed++;
        $display("FAIL rr_cycle%0d got ready=%b valid=%b exp ready=%b valid=%b",
                 k, req_ready, iss_valid, one << (k % 4), k > 0);
      end
      if (k > 0) begin
        tests_run++;
        if (iss_src !== 2'((k - 1) % 4)) begin
          tests_failed++; $display("FAIL rr_src%0d got %0d exp %0d", k, iss_src, (k - 1) % 4);
        end
      end
      tick();
    end
    tests_run++;
    if (iss_src !== 2'd0 || iss_valid !== 1'b1) begin
      tests_failed++; $display("FAIL rr_fifth got src=%0d v=%b exp src=0 v=1", iss_src, iss_valid);
    end
    req_valid = '0; tick();
  endtask

  task automatic test_operand();
    reset_dut();
    set_req(2, OP_IMM, 32'h0000_1234, 32'd5, 32'hFFFF_FFF0, 6'h2A);
    req_valid = 4'b0100; iss_ready = 1;
    tick();
    tests_run++;
    if (iss_op_b !== 32'hFFFF_FFF0 || iss_op_a !== 32'h0000_1234 || iss_src !== 2'd2) begin
      tests_failed++;
      $display("FAIL opimm got a=%h b=%h src=%0d exp a=00001234 b=fffffff0 src=2",
               iss_op_a, iss_op_b, iss_src);
    end
    set_req(2, OP, 32'h0000_1234, 32'd5, 32'hFFFF_FFF0, 6'h2B);
    tick();
    tests_run++;
    if (iss_op_b !== 32'd5 || iss_opcode !== OP || iss_tag !== 6'h2B) begin
      tests_failed++;
      $display("FAIL op_reg got b=%h opc=%h tag=%h exp b=00000005 opc=33 tag=2b",
               iss_op_b, iss_opcode, iss_tag);
    end
    req_valid = '0; tick();
  endtask

  task automatic test_stall();
    reset_dut();
    set_req(0, OP, 32'hAAAA_0001, 32'hBBBB_0001, 32'h0, 6'h11);
    req_valid = 4'b0001; iss_ready = 0;
    tick();
    set_req(1, OP, 32'hAAAA_0002, 32'hBBBB_0002, 32'h0, 6'h22);
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (req_ready !== '0 || iss_valid !== 1'b1 || iss_tag !== 6'h11 ||
          iss_op_a !== 32'hAAAA_0001 || iss_op_b !== 32'hBBBB_0001 || iss_src !== 2'd0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d got ready=%b v=%b tag=%h a=%h b=%h exp ready=0 v=1 tag=11",
                 k, req_ready, iss_valid, iss_tag, iss_op_a, iss_op_b);
      end
      tick();
    end
    iss_ready = 1; #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL stall_release_ready got %b exp 0010", req_ready);
    end
    tick();
    tests_run++;
    if (iss_valid !== 1'b1 || iss_tag !== 6'h22 || iss_src !== 2'd1) begin
      tests_failed++;
      $display("FAIL stall_no_bubble got v=%b tag=%h src=%0d exp v=1 tag=22 src=1",
               iss_valid, iss_tag, iss_src);
    end
    req_valid = '0; tick();
  endtask

  task automatic test_wrap();
    reset_dut();
    randomize_fields();
    iss_ready = 1; req_valid = 4'b0100;
    tick();
    req_valid = 4'b0101; #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++; $display("FAIL wrap_grant0 got %b exp 0001", req_ready);
    end
    tick();
    #1;
    tests_run++;
    if (iss_src !== 2'd0 || req_ready !== 4'b0100) begin
      tests_failed++; $display("FAIL wrap_next got src=%0d ready=%b exp src=0 ready=0100",
                               iss_src, req_ready);
    end
    tick();
    tests_run++;
    if (iss_src !== 2'd2) begin
      tests_failed++; $display("FAIL wrap_src2 got %0d exp 2", iss_src);
    end
    req_valid = '0; tick();
  endtask

  task automatic test_flush();
    reset_dut();
    randomize_fields();
    req_valid = 4'b0001; iss_ready = 0;
    tick();
    req_valid = 4'b1111; flush = 1; #1;
    tests_run++;
    if (req_ready !== '0) begin
      tests_failed++; $display("FAIL flush_ready got %b exp 0000", req_ready);
    end
    tick();
    flush = 0;
    tests_run++;
    if (iss_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_valid got %b exp 0", iss_valid);
    end
    iss_ready = 1; #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++; $display("FAIL flush_rr_kept got %b exp 0010", req_ready);
    end
    tick();
    req_valid = '0; tick();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    reset_dut();
    randomize_fields();
    req_valid = 4'b0010; iss_ready = 1;
    repeat (10) tick();
    req_valid = '0; iss_ready = 0;
    repeat (4) tick();
    tests_run++;
    if (perf_grant_cnt[1*CNT_W +: CNT_W] !== 32'd10 || perf_stall_cnt !== 32'd4) begin
      tests_failed++;
      $display("FAIL perf_counts got g1=%0d s=%0d exp g1=10 s=4",
               perf_grant_cnt[1*CNT_W +: CNT_W], perf_stall_cnt);
    end
    rst = 1; tick(); rst = 0;
    tests_run++;
    if (perf_grant_cnt !== '0 || perf_stall_cnt !== '0) begin
      tests_failed++; $display("FAIL perf_rst got g=%h s=%h exp 0", perf_grant_cnt, perf_stall_cnt);
    end
  endtask
`endif

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      randomize_fields();
      req_valid = N'($urandom);
      iss_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 49) == 0);
      #1;
      tests_run++;
      if (req_ready !== exp_ready() || iss_valid !== m_valid) begin
        tests_failed++;
        $display("FAIL rand_ctrl c=%0d got ready=%b v=%b exp ready=%b v=%b",
                 c, req_ready, iss_valid, exp_ready(), m_valid);
      end
      if (m_valid) begin
        tests_run++;
        if ({iss_opcode, iss_funct3, iss_funct7, iss_op_a, iss_op_b, iss_tag, iss_src} !==
            {m_opcode, m_funct3, m_funct7, m_a, m_b, m_tag, 2'(m_src)}) begin
          tests_failed++;
          $display("FAIL rand_data c=%0d got opc=%h a=%h b=%h tag=%h src=%0d exp opc=%h a=%h b=%h tag=%h src=%0d",
                   c, iss_opcode, iss_op_a, iss_op_b, iss_tag, iss_src,
                   m_opcode, m_a, m_b, m_tag, m_src);
        end
      end
`ifdef ALU_ARB_PERF_EN
      begin
        logic [N*CNT_W-1:0] eg;
        for (int i = 0; i < N; i++) eg[i*CNT_W +: CNT_W] = m_gcnt[i];
        tests_run++;
        if (perf_grant_cnt !== eg || perf_stall_cnt !== m_stall) begin
          tests_failed++;
          $display("FAIL rand_perf c=%0d got g=%h s=%0d exp g=%h s=%0d",
                   c, perf_grant_cnt, perf_stall_cnt, eg, m_stall);
        end
      end
`endif
      tick();
    end
    rst = 0; flush = 0; req_valid = '0;
  endtask

  initial begin
    rst = 1; flush = 0; iss_ready = 0; req_valid = '0;
    req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_tag = '0;
    test_reset();
    test_round_robin();
    test_operand();
    test_stall();
    test_wrap();
    test_flush();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
